control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: COUNT_W, default 16, width of the retired-instruction counter; used only when CU_INSTR_COUNT_EN is defined.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: decoded_instruction  input  decoded_instruction_type (k_and_s_pkg)  current instruction class from data_path.
REQ-005 Port: zero_op, neg_op, unsigned_overflow, signed_overflow  input  1 each  registered flags from data_path.
REQ-006 Port: branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable  output  1 each  data_path controls.
REQ-007 Port: operation  output  2  ALU select: 00 add, 01 and, 10 or, 11 sub.
REQ-008 Port: ram_write_enable  output  1  RAM write strobe.
REQ-009 Port: halt  output  1  processor stopped.
REQ-010 addr_sel encoding: 0 = program counter, 1 = instruction memory address. c_sel encoding: 0 = ALU result, 1 = data_in.

Function
REQ-011 Moore FSM with states FETCH, DECODE, LOAD_ADDR, LOAD_WB, STORE, EXEC, HALTED; every output is a function of the state and of the registered decoded_instruction and flags only.
REQ-012 Outputs not listed for a state are 0.
REQ-013 FETCH: addr_sel=0, ir_enable=1. Next state is DECODE.
REQ-014 DECODE: all outputs 0. The next state depends on the instruction class:
- I_LOAD -> LOAD_ADDR
- I_STORE -> STORE
- I_HALT -> HALTED
- all other classes -> EXEC
REQ-015 LOAD_ADDR: addr_sel=1. Next state is LOAD_WB.
REQ-016 LOAD_WB: addr_sel=1, c_sel=1, write_reg_enable=1, pc_enable=1, branch=0. Next state is FETCH.
REQ-017 STORE: addr_sel=1, ram_write_enable=1, pc_enable=1, branch=0. Next state is FETCH.
REQ-018 EXEC with I_ADD, I_SUB, I_AND or I_OR: operation=00/11/01/10 respectively, c_sel=0, write_reg_enable=1, flags_reg_enable=1, pc_enable=1. Next state is FETCH.
REQ-019 EXEC with I_MOVE: operation=10, write_reg_enable=1, flags_reg_enable=0, pc_enable=1. Next state is FETCH.
REQ-020 EXEC with a branch class: pc_enable=1, branch=taken. Taken conditions:
- I_BRANCH: always
- I_BZERO: zero_op
- I_BNZERO: !zero_op
- I_BNEG: neg_op
- I_BNNEG: !neg_op
- I_BOV: signed_overflow
- I_BNOV: !signed_overflow
REQ-021 EXEC with I_NOP or any unlisted class: pc_enable=1, branch=0. Next state is FETCH.
REQ-022 HALTED: halt=1 and all other outputs 0; the FSM stays in HALTED until reset.
REQ-023 Latency in cycles: LOAD 4; STORE, ALU, MOVE, branch and NOP 3; HALT reaches HALTED 2 cycles after FETCH.
REQ-024 pc_enable is asserted exactly once per retired instruction. Branch and flag tests use the flag values present during EXEC.
REQ-025 ram_write_enable and write_reg_enable are never asserted in the same cycle.

Reset
REQ-026 When rst_n=0: state=FETCH immediately (asynchronous); every output is 0 (including halt); the counter is 0.
REQ-027 A reset asserted mid-instruction or while HALTED aborts the instruction with no further writes.
REQ-028 The first FETCH occurs on the first rising clk edge after rst_n rises.

Configuration
REQ-029 Macro CU_INSTR_COUNT_EN.
- Defined: adds output instr_count [COUNT_W-1:0]. It increments by 1 on every cycle with pc_enable=1 and wraps from all-ones to 0.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Verification
REQ-030 Reset, then I_ADD -> FETCH(ir_enable=1), DECODE, EXEC(operation=00, write_reg_enable=1, flags_reg_enable=1, pc_enable=1); back in FETCH on cycle 4.
REQ-031 I_LOAD -> addr_sel=1 on cycles 3-4; c_sel=1 and write_reg_enable=1 only on cycle 4; STORE -> ram_write_enable=1 for exactly one cycle.
REQ-032 I_BZERO with zero_op=1 -> branch=1, pc_enable=1 in EXEC; with zero_op=0 -> branch=0, pc_enable=1; same pair of checks for BNEG/BNNEG/BOV/BNOV/BNZERO.
REQ-033 I_HALT -> halt=1 from cycle 3 and held for 20 cycles regardless of inputs; rst_n pulse -> halt=0 immediately, FETCH resumes.
REQ-034 rst_n asserted during LOAD_ADDR -> outputs 0 in the same cycle with no write_reg_enable pulse; with CU_INSTR_COUNT_EN and COUNT_W=4, 17 NOPs -> instr_count=1.

Source files
------------

// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: instruction classes shared by the data path and the control unit.
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
        I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_HALT
    } decoded_instruction_type;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: decoded instruction and flags towards the control unit, data path controls back.
interface control_unit_if;
    import k_and_s_pkg::*;
    decoded_instruction_type decoded_instruction;
    logic       zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic       branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable;
    logic [1:0] operation;
    logic       ram_write_enable, halt;
    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        output branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable,
               operation, ram_write_enable, halt
    );
    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow, signed_overflow,
        input  branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable,
               operation, ram_write_enable, halt
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing fetch/decode/execute for the data path.
// Optional retired-instruction counter enabled by CU_INSTR_COUNT_EN.
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    control_unit_if.master bus
`ifdef CU_INSTR_COUNT_EN
    ,
    output logic [COUNT_W-1:0] instr_count
`endif
);
    typedef enum logic [2:0] {FETCH, DECODE, LOAD_ADDR, LOAD_WB, STORE, EXEC, HALTED} state_t;

    state_t state_q, state_d;
    logic run_q, run_d;
    logic branch, pc_en, ir_en, addr_sel, c_sel, wr_en, flags_en, ram_we, halt;
    logic [1:0] operation;
    decoded_instruction_type ins;

    assign ins = bus.decoded_instruction;

    // run_q holds outputs at 0 until the first edge after reset release, which starts FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_d     = 1'b1;
        branch    = 1'b0;
        pc_en     = 1'b0;
        ir_en     = 1'b0;
        addr_sel  = 1'b0;
        c_sel     = 1'b0;
        wr_en     = 1'b0;
        flags_en  = 1'b0;
        ram_we    = 1'b0;
        halt      = 1'b0;
        operation = 2'b00;
        if (run_q) begin
            case (state_q)
                FETCH: begin
                    ir_en   = 1'b1;
                    state_d = DECODE;
                end
                DECODE: state_d = ins == I_LOAD  ? LOAD_ADDR :
                                  ins == I_STORE ? STORE :
                                  ins == I_HALT  ? HALTED : EXEC;
                LOAD_ADDR: begin
                    addr_sel = 1'b1;
                    state_d  = LOAD_WB;
                end
                LOAD_WB: begin
                    addr_sel = 1'b1;
                    c_sel    = 1'b1;
                    wr_en    = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = FETCH;
                end
                STORE: begin
                    addr_sel = 1'b1;
                    ram_we   = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = FETCH;
                end
                EXEC: begin
                    pc_en   = 1'b1;
                    state_d = FETCH;
                    case (ins)
                        I_ADD, I_SUB, I_AND, I_OR: begin
                            operation = ins == I_SUB ? 2'b11 : ins == I_AND ? 2'b01 :
                                        ins == I_OR  ? 2'b10 : 2'b00;
                            wr_en     = 1'b1;
                            flags_en  = 1'b1;
                        end
                        I_MOVE: begin
                            operation = 2'b10;
                            wr_en     = 1'b1;
                        end
                        I_BRANCH: branch = 1'b1;
                        I_BZERO:  branch = bus.zero_op;
                        I_BNZERO: branch = !bus.zero_op;
                        I_BNEG:   branch = bus.neg_op;
                        I_BNNEG:  branch = !bus.neg_op;
                        I_BOV:    branch = bus.signed_overflow;
                        I_BNOV:   branch = !bus.signed_overflow;
                        default:  branch = 1'b0;
                    endcase
                end
                HALTED: halt = 1'b1;
                default: state_d = FETCH;
            endcase
        end
    end

    assign bus.branch           = branch;
    assign bus.pc_enable        = pc_en;
    assign bus.ir_enable        = ir_en;
    assign bus.addr_sel         = addr_sel;
    assign bus.c_sel            = c_sel;
    assign bus.write_reg_enable = wr_en;
    assign bus.flags_reg_enable = flags_en;
    assign bus.operation        = operation;
    assign bus.ram_write_enable = ram_we;
    assign bus.halt             = halt;

`ifdef CU_INSTR_COUNT_EN
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d = cnt_q + COUNT_W'(pc_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign instr_count = cnt_q;
`endif
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vectors for control_unit; output word is
// {halt, ram_we, operation[1:0], flags_en, wr_en, c_sel, addr_sel, ir_en, pc_en, branch}.
module tb_control_unit;
    import k_and_s_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    control_unit_if bus ();

`ifdef CU_INSTR_COUNT_EN
    logic [3:0] instr_count;
    control_unit #(.COUNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .instr_count(instr_count));
`else
    control_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    localparam logic [10:0] O_FETCH = 11'h004, O_DEC = 11'h000, O_ADD = 11'h062, O_SUB = 11'h1E2,
                            O_AND = 11'h0E2, O_OR = 11'h162, O_MOVE = 11'h122, O_NOP = 11'h002,
                            O_TAKEN = 11'h003, O_LDA = 11'h008, O_LDWB = 11'h03A, O_ST = 11'h20A,
                            O_HALT = 11'h400;

    function automatic logic [10:0] outs();
        return {bus.halt, bus.ram_write_enable, bus.operation, bus.flags_reg_enable,
                bus.write_reg_enable, bus.c_sel, bus.addr_sel, bus.ir_enable, bus.pc_enable,
                bus.branch};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at the negedge inside FETCH; leaves the bench at the negedge of the next FETCH.
    task automatic run(input string tag, input decoded_instruction_type i, input logic [3:0] f,
                       input int n, input logic [10:0] e2, input logic [10:0] e3);
        bus.decoded_instruction = i;
        {bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow} = f;
        check({tag, ".fetch"}, 32'(outs()), 32'(O_FETCH));
        @(negedge clk);
        check({tag, ".decode"}, 32'(outs()), 32'(O_DEC));
        @(negedge clk);
        check({tag, ".c3"}, 32'(outs()), 32'(e2));
        if (n == 4) begin
            @(negedge clk);
            check({tag, ".c4"}, 32'(outs()), 32'(e3));
        end
        @(negedge clk);
    endtask

    initial begin
        bus.decoded_instruction = I_NOP;
        {bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow} = 4'b0000;
        repeat (2) @(negedge clk);
        check("reset_outs", 32'(outs()), 0);
        rst_n = 1'b1;
        check("pre_first_edge", 32'(outs()), 0);
        @(negedge clk);
        run("add", I_ADD, 4'b0000, 3, O_ADD, 0);
        check("add.back_fetch", 32'(outs()), 32'(O_FETCH));
        run("sub", I_SUB, 4'b0000, 3, O_SUB, 0);
        run("and", I_AND, 4'b0000, 3, O_AND, 0);
        run("or", I_OR, 4'b0000, 3, O_OR, 0);
        run("move", I_MOVE, 4'b0000, 3, O_MOVE, 0);
        run("nop", I_NOP, 4'b1111, 3, O_NOP, 0);
        run("load", I_LOAD, 4'b0000, 4, O_LDA, O_LDWB);
        run("store", I_STORE, 4'b0000, 3, O_ST, 0);
        check("store.single_we", 32'(outs()), 32'(O_FETCH));
        run("branch", I_BRANCH, 4'b0000, 3, O_TAKEN, 0);
        run("bzero1", I_BZERO, 4'b1000, 3, O_TAKEN, 0);
        run("bzero0", I_BZERO, 4'b0111, 3, O_NOP, 0);
        run("bnzero0", I_BNZERO, 4'b0000, 3, O_TAKEN, 0);
        run("bnzero1", I_BNZERO, 4'b1000, 3, O_NOP, 0);
        run("bneg1", I_BNEG, 4'b0100, 3, O_TAKEN, 0);
        run("bneg0", I_BNEG, 4'b1011, 3, O_NOP, 0);
        run("bnneg0", I_BNNEG, 4'b0000, 3, O_TAKEN, 0);
        run("bnneg1", I_BNNEG, 4'b0100, 3, O_NOP, 0);
        run("bov1", I_BOV, 4'b0001, 3, O_TAKEN, 0);
        run("bov0", I_BOV, 4'b1110, 3, O_NOP, 0);
        run("bnov0", I_BNOV, 4'b0010, 3, O_TAKEN, 0);
        run("bnov1", I_BNOV, 4'b0001, 3, O_NOP, 0);

        // Reset during LOAD_ADDR: outputs drop at once and no write-back follows.
        bus.decoded_instruction = I_LOAD;
        check("ldrst.fetch", 32'(outs()), 32'(O_FETCH));
        repeat (2) @(negedge clk);
        check("ldrst.addr", 32'(outs()), 32'(O_LDA));
        #2 rst_n = 1'b0;
        #1 check("ldrst.async", 32'(outs()), 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("ldrst.held", 32'(outs()), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("ldrst.resume", 32'(outs()), 32'(O_FETCH));

        // Halt is sticky whatever the inputs do.
        bus.decoded_instruction = I_HALT;
        @(negedge clk);
        check("halt.decode", 32'(outs()), 32'(O_DEC));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("halt.held", 32'(outs()), 32'(O_HALT));
            bus.decoded_instruction = decoded_instruction_type'(k[3:0]);
            {bus.zero_op, bus.neg_op, bus.unsigned_overflow, bus.signed_overflow} = 4'(k * 5);
        end
        #2 rst_n = 1'b0;
        #1 check("halt.reset", 32'(outs()), 0);
        #1 rst_n = 1'b1;
        bus.decoded_instruction = I_ADD;
        @(negedge clk);
        run("halt.resume_add", I_ADD, 4'b0000, 3, O_ADD, 0);

`ifdef CU_INSTR_COUNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        #1 check("cnt.reset", 32'(instr_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 17; k++) run("cnt.nop", I_NOP, 4'b0000, 3, O_NOP, 0);
        check("cnt.wrap", 32'(instr_count), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
